// File: rtl/uiip_pkg.sv
// IPv4 receive-side header constants, FSM encoding and small field helpers.
package uiip_pkg;

  localparam logic [3:0]  IP_VER     = 4'd4;
  localparam logic [3:0]  IP_IHL     = 4'd5;
  localparam logic [15:0] IP_HDR_LEN = 16'd20;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;
  localparam logic [31:0] BCAST_IP   = 32'hFFFF_FFFF;

  // Header byte offsets of the captured fields.
  localparam logic [15:0] OFS_TOTLEN_HI = 16'd2;
  localparam logic [15:0] OFS_TOTLEN_LO = 16'd3;
  localparam logic [15:0] OFS_FRAG_HI   = 16'd6;
  localparam logic [15:0] OFS_FRAG_LO   = 16'd7;
  localparam logic [15:0] OFS_PROTO     = 16'd9;
  localparam logic [15:0] OFS_SRC0      = 16'd12;
  localparam logic [15:0] OFS_SRC1      = 16'd13;
  localparam logic [15:0] OFS_SRC2      = 16'd14;
  localparam logic [15:0] OFS_SRC3      = 16'd15;
  localparam logic [15:0] OFS_DST0      = 16'd16;
  localparam logic [15:0] OFS_DST1      = 16'd17;
  localparam logic [15:0] OFS_DST2      = 16'd18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_DROP,
    ST_DONE
  } state_t;

  // MF flag plus 13-bit fragment offset; any nonzero bit means a fragment.
  function automatic logic is_fragment(input logic [13:0] mf_off);
    return mf_off[13] || (mf_off[12:0] != '0);
  endfunction

  function automatic logic dst_accepted(input logic [31:0] dst,
                                        input logic [31:0] local_ip);
    return (dst == local_ip) || (dst == BCAST_IP);
  endfunction

endpackage

// File: rtl/uiip_rx_header_parse.sv
// IPv4 RX header parser: walks the 20-byte header, mirrors it to the checksum
// checker, validates fields, strips header and Ethernet padding, forwards the
// datagram payload and issues a per-datagram done/error verdict.
module uiip_rx_header_parse
  import uiip_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP      = 32'hC0A8_0102,
  parameter logic [7:0]  IP_PROTO      = PROTO_UDP,
  parameter logic [15:0] MIN_TOTAL_LEN = 16'd28
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_mac_rdata_valid,
  input  logic [7:0]  I_mac_rdata,
  input  logic        I_checksum_rerror,
  output logic        O_ip_rdata_valid,
  output logic [7:0]  O_ip_rdata,
  output logic        O_udp_rdata_valid,
  output logic [7:0]  O_udp_rdata,
  output logic [31:0] O_src_ip,
  output logic [15:0] O_payload_len,
  output logic        O_pkt_done,
  output logic        O_pkt_error
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_skip;        // remainder of a frame cut by reset is ignored
  logic [15:0] r_byte_cnt;
  logic [15:0] r_rem;
  logic [7:0]  r_ver_ihl;
  logic [15:0] r_tot_len;
  logic [13:0] r_mf_off;
  logic [7:0]  r_proto;
  logic [31:0] r_src;
  logic [23:0] r_dst_hi;
  logic        r_err;

  logic [31:0] w_dst;
  logic        w_hdr_last;
  logic        w_hdr_bad;
  logic [15:0] w_pay_len;
  logic        w_start;
  logic        w_ip_vld;
  logic        w_udp_vld;
  logic        w_done;
  logic        w_err;

  // Header verdict, evaluated on byte 19 using the live last destination byte.
  always_comb begin
    w_dst      = {r_dst_hi, I_mac_rdata};
    w_start    = (r_state == ST_IDLE) && I_mac_rdata_valid && !r_skip;
    w_hdr_last = (r_state == ST_HDR) && I_mac_rdata_valid &&
                 (r_byte_cnt == IP_HDR_LEN - 16'd1);
    w_pay_len  = r_tot_len - IP_HDR_LEN;
    w_hdr_bad  = (r_ver_ihl != {IP_VER, IP_IHL}) ||
                 is_fragment(r_mf_off) ||
                 (r_proto != IP_PROTO) ||
                 (r_tot_len < MIN_TOTAL_LEN) ||
                 !dst_accepted(w_dst, LOCAL_IP);
  end

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!I_mac_rdata_valid) begin
          w_state_nxt = ST_DONE;
        end else if (w_hdr_last) begin
          w_state_nxt = w_hdr_bad ? ST_DROP : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!I_mac_rdata_valid) begin
          w_state_nxt = ST_DONE;
        end else if (r_rem == 16'd1) begin
          w_state_nxt = ST_PAD;
        end
      end
      ST_PAD, ST_DROP: begin
        if (!I_mac_rdata_valid) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered byte streams and verdict.
  always_comb begin
    w_ip_vld  = I_mac_rdata_valid && (w_start || (r_state == ST_HDR));
    w_udp_vld = I_mac_rdata_valid && (r_state == ST_PAYLOAD);
    w_done    = (r_state == ST_DONE);
    w_err     = r_err || I_checksum_rerror;
  end

  // Registered byte streams and done/error pulse.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_ip_rdata_valid  <= 1'b0;
      O_ip_rdata        <= '0;
      O_udp_rdata_valid <= 1'b0;
      O_udp_rdata       <= '0;
      O_pkt_done        <= 1'b0;
      O_pkt_error       <= 1'b0;
    end else begin
      O_ip_rdata_valid  <= w_ip_vld;
      O_ip_rdata        <= w_ip_vld ? I_mac_rdata : '0;
      O_udp_rdata_valid <= w_udp_vld;
      O_udp_rdata       <= w_udp_vld ? I_mac_rdata : '0;
      O_pkt_done        <= w_done;
      O_pkt_error       <= w_done && w_err;
    end
  end

  // Reset-abort tracking: a frame still in flight during reset is skipped
  // until the MAC drops valid, so its tail is never parsed as a new header.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_skip <= I_mac_rdata_valid;
    end else if ((r_state == ST_IDLE) && !I_mac_rdata_valid) begin
      r_skip <= 1'b0;
    end
  end

  // Header field capture, remaining-length counter and sticky error.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_byte_cnt    <= '0;
      r_rem         <= '0;
      r_ver_ihl     <= '0;
      r_tot_len     <= '0;
      r_mf_off      <= '0;
      r_proto       <= '0;
      r_src         <= '0;
      r_dst_hi      <= '0;
      r_err         <= 1'b0;
      O_src_ip      <= '0;
      O_payload_len <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ver_ihl  <= I_mac_rdata;
            r_byte_cnt <= 16'd1;
            r_err      <= 1'b0;
          end
        end
        ST_HDR: begin
          if (I_mac_rdata_valid) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
            case (r_byte_cnt)
              OFS_TOTLEN_HI: r_tot_len[15:8] <= I_mac_rdata;
              OFS_TOTLEN_LO: r_tot_len[7:0]  <= I_mac_rdata;
              OFS_FRAG_HI:   r_mf_off[13:8]  <= I_mac_rdata[5:0];
              OFS_FRAG_LO:   r_mf_off[7:0]   <= I_mac_rdata;
              OFS_PROTO:     r_proto         <= I_mac_rdata;
              OFS_SRC0:      r_src[31:24]    <= I_mac_rdata;
              OFS_SRC1:      r_src[23:16]    <= I_mac_rdata;
              OFS_SRC2:      r_src[15:8]     <= I_mac_rdata;
              OFS_SRC3:      r_src[7:0]      <= I_mac_rdata;
              OFS_DST0:      r_dst_hi[23:16] <= I_mac_rdata;
              OFS_DST1:      r_dst_hi[15:8]  <= I_mac_rdata;
              OFS_DST2:      r_dst_hi[7:0]   <= I_mac_rdata;
              default: ;
            endcase
            if (w_hdr_last) begin
              O_src_ip      <= r_src;
              O_payload_len <= w_pay_len;
              r_rem         <= w_pay_len;
              r_err         <= w_hdr_bad;
            end
          end else begin
            // Frame ended before the header was complete.
            r_err <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (I_mac_rdata_valid) begin
            r_rem <= r_rem - 16'd1;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uiip_rx_header_parse.sv
// Randomized self-checking bench for uiip_rx_header_parse with a byte-level
// reference model of IPv4 header acceptance and payload extraction.
module tb_uiip_rx_header_parse;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0102;
  localparam logic [31:0] BCAST    = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [7:0]  in_data;
  logic        ck_err;
  logic        ip_vld;
  logic [7:0]  ip_data;
  logic        udp_vld;
  logic [7:0]  udp_data;
  logic [31:0] src_ip;
  logic [15:0] pay_len;
  logic        done;
  logic        err;

  uiip_rx_header_parse #(
    .LOCAL_IP      (LOCAL_IP),
    .IP_PROTO      (8'd17),
    .MIN_TOTAL_LEN (16'd28)
  ) dut (
    .I_clk             (clk),
    .I_reset           (rst),
    .I_mac_rdata_valid (in_vld),
    .I_mac_rdata       (in_data),
    .I_checksum_rerror (ck_err),
    .O_ip_rdata_valid  (ip_vld),
    .O_ip_rdata        (ip_data),
    .O_udp_rdata_valid (udp_vld),
    .O_udp_rdata       (udp_data),
    .O_src_ip          (src_ip),
    .O_payload_len     (pay_len),
    .O_pkt_done        (done),
    .O_pkt_error       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Captured DUT activity.
  logic [7:0]  got_ip[$];
  int unsigned got_ip_cyc[$];
  logic [7:0]  got_udp[$];
  int unsigned got_udp_cyc[$];
  int unsigned done_cnt;
  logic        done_err;
  logic [31:0] done_src;
  logic [15:0] done_plen;

  always @(negedge clk) begin
    if (ip_vld) begin
      got_ip.push_back(ip_data);
      got_ip_cyc.push_back(cyc);
    end
    if (udp_vld) begin
      got_udp.push_back(udp_data);
      got_udp_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_err  = err;
      done_src  = src_ip;
      done_plen = pay_len;
    end
  end

  // Frame under test and the cycle each byte was presented.
  logic [7:0]  tx[$];
  int unsigned drv_cyc[$];

  // Reference state: last completed header's source and payload length.
  logic [31:0] m_src  = '0;
  logic [15:0] m_plen = '0;

  task automatic build_frame(input logic [31:0] dst, input logic [7:0] proto,
                             input logic [7:0] vihl, input logic [15:0] tot,
                             input bit mf, input logic [12:0] off,
                             input int unsigned n);
    logic [7:0] hdr [0:19];
    hdr[0]  = vihl;
    hdr[1]  = 8'($urandom);
    hdr[2]  = tot[15:8];
    hdr[3]  = tot[7:0];
    hdr[4]  = 8'($urandom);
    hdr[5]  = 8'($urandom);
    hdr[6]  = {1'b0, 1'($urandom), mf, off[12:8]};
    hdr[7]  = off[7:0];
    hdr[8]  = 8'd64;
    hdr[9]  = proto;
    hdr[10] = 8'($urandom);
    hdr[11] = 8'($urandom);
    for (int i = 12; i < 16; i++) hdr[i] = 8'($urandom);
    hdr[16] = dst[31:24];
    hdr[17] = dst[23:16];
    hdr[18] = dst[15:8];
    hdr[19] = dst[7:0];
    tx.delete();
    for (int unsigned i = 0; i < n; i++) begin
      if (i < 20) tx.push_back(hdr[i]);
      else        tx.push_back(8'($urandom));
    end
  endtask

  function automatic bit model_hdr_bad();
    logic [15:0] tot;
    logic [31:0] dst;
    logic [7:0]  b6;
    logic [7:0]  b7;
    tot = {tx[2], tx[3]};
    dst = {tx[16], tx[17], tx[18], tx[19]};
    b6  = tx[6];
    b7  = tx[7];
    return (tx[0] != 8'h45) || b6[5] || ({b6[4:0], b7} != 13'd0) ||
           (tx[9] != 8'd17) || (tot < 16'd28) ||
           ((dst != LOCAL_IP) && (dst != BCAST));
  endfunction

  task automatic clear_capture();
    got_ip.delete();
    got_ip_cyc.delete();
    got_udp.delete();
    got_udp_cyc.delete();
    drv_cyc.delete();
    done_cnt = 0;
    done_err = 1'b0;
  endtask

  task automatic drive_bytes();
    foreach (tx[i]) begin
      @(posedge clk); #1;
      in_vld  = 1'b1;
      in_data = tx[i];
      drv_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    in_vld  = 1'b0;
    in_data = '0;
  endtask

  task automatic run_frame(input bit ck);
    int unsigned n;
    int unsigned n_ip;
    int unsigned end_pay;
    logic [15:0] tot;
    bit          bad;
    bit          exp_err;
    logic [7:0]  exp_pay[$];
    int unsigned exp_pay_idx[$];

    clear_capture();
    ck_err = ck;
    drive_bytes();
    repeat (6) @(posedge clk);
    #1 ck_err = 1'b0;

    n = tx.size();
    n_ip = (n < 20) ? n : 20;
    exp_pay.delete();
    exp_pay_idx.delete();
    if (n >= 20) begin
      tot = {tx[2], tx[3]};
      bad = model_hdr_bad();
      m_src  = {tx[12], tx[13], tx[14], tx[15]};
      m_plen = tot - 16'd20;
      exp_err = bad || (n < int'(tot)) || ck;
      if (!bad) begin
        end_pay = (n < int'(tot)) ? n : int'(tot);
        for (int unsigned i = 20; i < end_pay; i++) begin
          exp_pay.push_back(tx[i]);
          exp_pay_idx.push_back(i);
        end
      end
    end else begin
      exp_err = 1'b1;
    end

    check("done_count", done_cnt, 1);
    check("done_error", {31'd0, done_err}, {31'd0, exp_err});
    check("src_ip", done_src, m_src);
    check("payload_len", {16'd0, done_plen}, {16'd0, m_plen});
    check("ip_count", got_ip.size(), n_ip);
    for (int unsigned i = 0; i < n_ip && i < got_ip.size(); i++) begin
      check("ip_byte", {24'd0, got_ip[i]}, {24'd0, tx[i]});
      check("ip_latency", got_ip_cyc[i], drv_cyc[i] + 1);
    end
    check("udp_count", got_udp.size(), exp_pay.size());
    for (int unsigned i = 0; i < exp_pay.size() && i < got_udp.size(); i++) begin
      check("udp_byte", {24'd0, got_udp[i]}, {24'd0, exp_pay[i]});
      check("udp_latency", got_udp_cyc[i], drv_cyc[exp_pay_idx[i]] + 1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ip_vld"},  {31'd0, ip_vld},  32'd0);
    check({tag, "_ip_data"}, {24'd0, ip_data}, 32'd0);
    check({tag, "_udp_vld"}, {31'd0, udp_vld}, 32'd0);
    check({tag, "_udp_data"},{24'd0, udp_data},32'd0);
    check({tag, "_src_ip"},  src_ip,           32'd0);
    check({tag, "_pay_len"}, {16'd0, pay_len}, 32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
    check({tag, "_err"},     {31'd0, err},     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dst;
    logic [7:0]  proto;
    logic [7:0]  vihl;
    logic [15:0] tot;
    bit          mf;
    logic [12:0] off;
    int unsigned n;
    int unsigned pad;
    int unsigned sel;

    rst = 1'b1; in_vld = 1'b0; in_data = '0; ck_err = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed frames.
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 44); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 44); run_frame(1'b1);
    build_frame(32'hC0A8_0109, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 36); run_frame(1'b0);
    build_frame(BCAST, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 40); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd6, 8'h45, 16'd36, 1'b0, 13'd0, 36); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h46, 16'd36, 1'b0, 13'd0, 36); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b1, 13'd0, 36); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd1, 36); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd100, 1'b0, 13'd0, 60); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd27, 1'b0, 13'd0, 30); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd28, 1'b0, 13'd0, 28); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 12); run_frame(1'b0);
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'hFFFF, 1'b0, 13'd0, 40); run_frame(1'b0);

    // Reset at header byte 10 with valid still high: frame is abandoned.
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 44);
    clear_capture();
    foreach (tx[i]) begin
      @(posedge clk); #1;
      if (i == 11) check_outputs_zero("midreset");
      rst     = (i == 10);
      in_vld  = 1'b1;
      in_data = tx[i];
    end
    @(posedge clk); #1;
    rst = 1'b0; in_vld = 1'b0; in_data = '0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_done_count", done_cnt, 0);
    check("abort_udp_count", got_udp.size(), 0);
    check("abort_ip_count", got_ip.size(), 10);
    m_src  = '0;
    m_plen = '0;
    build_frame(LOCAL_IP, 8'd17, 8'h45, 16'd36, 1'b0, 13'd0, 40); run_frame(1'b0);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      sel   = $urandom_range(0, 99);
      dst   = (sel < 70) ? LOCAL_IP : (sel < 85) ? BCAST : $urandom;
      proto = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd17;
      vihl  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h45;
      mf    = ($urandom_range(0, 9) == 0);
      off   = ($urandom_range(0, 9) == 0) ? 13'($urandom) : 13'd0;
      tot   = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 27))
                                           : 16'($urandom_range(28, 90));
      pad   = $urandom_range(0, 10);
      n     = int'(tot) + pad;
      if (n < 20) n = 20 + pad;
      if ($urandom_range(0, 6) == 0) n = $urandom_range(1, n);
      build_frame(dst, proto, vihl, tot, mf, off, n);
      run_frame($urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uiip_rx_header_parse.md
Name: uiip_rx_header_parse

Overview:
Receive-side IPv4 layer stage. Sits between the MAC RX type demux, which delivers IPv4 frame payload bytes, and the UDP RX stage. It walks the 20-byte IPv4 header, mirrors header bytes to the header-checksum checker, validates the header fields, strips header and Ethernet padding, and forwards the datagram payload. It issues a per-datagram done/error verdict.

Parameters:
LOCAL_IP, 32'hC0A8_0102, accepted destination address; 32'hFFFF_FFFF is always accepted as well.
IP_PROTO, 8'd17, accepted protocol number (UDP).
MIN_TOTAL_LEN, 16'd28, smallest legal total length (IP header plus UDP header).

Ports:
I_clk  in  1  system clock.
I_reset  in  1  synchronous, active-high reset.
I_mac_rdata_valid  in  1  high for every byte of one IPv4 frame payload, contiguous; low between frames.
I_mac_rdata  in  8  frame byte, first byte = version/IHL.
I_checksum_rerror  in  1  verdict from the header-checksum checker; valid from 3 cycles after the last header byte until checker valid drops.
O_ip_rdata_valid  out  1  header-byte strobe to the checksum checker.
O_ip_rdata  out  8  header byte to the checksum checker.
O_udp_rdata_valid  out  1  payload byte strobe.
O_udp_rdata  out  8  payload byte.
O_src_ip  out  32  source address, held from the header's end until the next header's end.
O_payload_len  out  16  total length − 20, same hold rule as O_src_ip.
O_pkt_done  out  1  one-cycle pulse at the end of every datagram attempt.
O_pkt_error  out  1  qualifies O_pkt_done; 1 = downstream discards the datagram.

Behaviour:
- One clock and reset: I_clk, with I_reset synchronous and active-high. Every register is updated only on the rising edge of I_clk.
- Reset: all outputs are 0, state is IDLE, and counters and sticky error are cleared. Reset asserted mid-frame aborts the frame silently, with no done pulse. The rest of that frame is ignored: the block waits in IDLE-wait until valid is low.
- Latency: every output byte stream is registered, so input byte n appears exactly 1 cycle later.
- O_ip_rdata_valid/O_ip_rdata carry header bytes 0..19 only and go low the cycle after byte 19. This gives the checker its mandatory idle gap.
- State IDLE:
  - Valid high → HDR with byte_cnt=1. Byte 0 is captured.
  - Valid low → stay in IDLE.
- State HDR, bytes 0..19 (byte_cnt is 16 bits):
  - Capture version/IHL (byte 0), total length (bytes 2-3), flags/fragment offset (bytes 6-7), protocol (byte 9), source IP (bytes 12-15) and destination IP (bytes 16-19).
  - The sticky header error is set if any of the following holds:
    - version ≠ 4 or IHL ≠ 5;
    - the MF flag is set or the fragment offset ≠ 0;
    - protocol ≠ IP_PROTO;
    - total length < MIN_TOTAL_LEN;
    - destination ≠ LOCAL_IP and destination ≠ broadcast.
  - After byte 19: O_src_ip and O_payload_len update, rem = total length − 20, and the state goes to PAYLOAD if there is no header error, else DROP.
- State PAYLOAD:
  - Each valid byte is forwarded and rem is decremented.
  - On the byte that makes rem = 0, the state goes to PAD.
  - Valid dropping while rem > 0 is a truncation: set the error, go to DONE.
- State PAD: bytes beyond the total length (Ethernet padding) are consumed and not forwarded. Valid low → DONE.
- State DROP: bytes are consumed and not forwarded. Valid low → DONE.
- State DONE (1 cycle):
  - O_pkt_done=1.
  - O_pkt_error = header error | truncation | the I_checksum_rerror sample taken in this cycle.
  - A frame that ends inside HDR (fewer than 20 bytes) gives done with error=1.
  - Next state is IDLE. A frame starting in the DONE cycle is not supported, because the upstream guarantees at least a 1-cycle gap.
- Checksum timing: the checker's verdict is valid from 3 cycles after the last header byte until its input valid drops. Because payload ≥ 8 bytes, the DONE cycle always falls inside the verdict window.
- Total length = 65535: rem = 65515 with no overflow, since all length arithmetic is 16-bit unsigned.
- Valid high continuously across two frames cannot occur (the MAC guarantees a gap).

Decomposition:
- Shared package uiip_pkg holds the header constants:
  - IP_VER=4, IP_IHL=5, IP_HDR_LEN=20;
  - PROTO_UDP=17, BCAST_IP;
  - state encodings IDLE/HDR/PAYLOAD/PAD/DROP/DONE.
- No sub-module is needed. The checksum checker is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Valid UDP frame: dst 192.168.1.2, total length 36, correct checksum, 8 trailing pad bytes → 16 payload bytes forwarded 1 cycle delayed, pad not forwarded, O_payload_len=16, done with error=0.
- Same frame with the checksum corrupted (checker reports error) → payload still forwarded, done with error=1.
- Destination 192.168.1.9 → nothing forwarded, done with error=1. Broadcast 255.255.255.255 → forwarded, error=0.
- Protocol 6, IHL 6, or MF set, each sent separately → no payload forwarded, done with error=1 in each case.
- Total length 100 but valid drops after 60 bytes → 40 bytes forwarded, then done with error=1.
- Reset asserted at header byte 10 while valid remains high → no done pulse, all outputs 0. The next frame after valid goes low parses correctly.
